mem_ctrl_pipe: RTL and testbench
================================

MEM_CTRL_PIPE -- requirements
Module: mem_ctrl_pipe

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: word width in bits; multiple of 8.
REQ-002 SHALL have parameter ADDR_WIDTH, default 7: word address width.
REQ-003 SHALL have parameter NUM_WORDS, default 128: implemented depth, at most 2**ADDR_WIDTH.
REQ-004 SHALL have parameter RD_LATENCY, default 1: cycles from request accept to response available; legal values 1 or 2.
REQ-005 SHALL have parameter INIT_BY, default 0: preload source (0 none, 1 inst.mem, 2 data.mem, via $readmemh).
REQ-006 SHALL have one clock and an asynchronous, active-high reset: clk input 1, rising-edge clock; rst input 1, asynchronous active-high reset.
REQ-007 SHALL have port req_valid, input, 1: request present.
REQ-008 SHALL have port req_ready, output, 1: request can be accepted.
REQ-009 SHALL have port req_we, input, 1: 1 store, 0 load.
REQ-010 SHALL have port req_addr, input, ADDR_WIDTH: word address.
REQ-011 SHALL have port req_wdata, input, DATA_WIDTH: store data.
REQ-012 SHALL have port req_wstrb, input, DATA_WIDTH/8: byte write strobes.
REQ-013 SHALL have port rsp_valid, output, 1: response present.
REQ-014 SHALL have port rsp_ready, input, 1: consumer takes response.
REQ-015 SHALL have port rsp_rdata, output, DATA_WIDTH: load data; DEADBEEF pattern for stores and errors.
REQ-016 SHALL have port rsp_err, output, 1: address was >= NUM_WORDS.

Function
REQ-017 A request SHALL be accepted on a rising clk edge where req_valid && req_ready; every accepted request SHALL produce exactly one response, in acceptance order.
REQ-018 An accepted store with in-range address SHALL update memory at that edge; bytes with a strobe of 0 SHALL keep their old value.
REQ-019 An accepted load SHALL return the memory word, including any store accepted in an earlier cycle.
REQ-020 The response SHALL be presentable on rsp_valid exactly RD_LATENCY cycles after acceptance when the response queue is empty and rsp_ready is high.
REQ-021 Responses SHALL enter a response FIFO of depth RD_LATENCY+1, and rsp_valid SHALL equal FIFO not-empty.
REQ-022 The head response SHALL pop on a clk edge with rsp_valid && rsp_ready, and rsp_valid/rsp_rdata/rsp_err SHALL hold stable while rsp_valid && !rsp_ready.
REQ-023 An outstanding counter SHALL track requests in the pipeline plus FIFO entries, and req_ready SHALL equal (outstanding < RD_LATENCY+1); no response SHALL ever be dropped.
REQ-024 On simultaneous accept and pop, outstanding SHALL be unchanged; on accept only, it SHALL increment; on pop only, it SHALL decrement.
REQ-025 For an out-of-range address, memory SHALL be unchanged, rsp_err SHALL be 1, and rsp_rdata SHALL be the DEADBEEF pattern.
REQ-026 Store responses SHALL carry rsp_err as defined above and rsp_rdata of the DEADBEEF pattern.
REQ-027 The DEADBEEF pattern SHALL be 32'hDEADBEEF replicated and truncated to DATA_WIDTH.
REQ-028 The FIFO read and write pointers SHALL wrap modulo RD_LATENCY+1.

Reset
REQ-029 While rst is asserted, the block SHALL drive rsp_valid=0, rsp_err=0, rsp_rdata=DEADBEEF pattern, req_ready=0, pipeline valid bits=0, FIFO pointers and outstanding=0.
REQ-030 One cycle after rst deasserts, req_ready SHALL be 1.
REQ-031 Reset mid-operation SHALL discard in-flight and queued responses, and memory contents SHALL be neither cleared nor reverted (stores accepted before reset persist).

Configuration
REQ-032 Macro MEM_BYTE_STROBE_EN SHALL control byte strobes: when defined, req_wstrb SHALL be honoured per REQ-018; when undefined, req_wstrb SHALL be ignored and every store SHALL write the full word.

Verification
REQ-033 Reset release, then store addr 3 data 32'hCAFEF00D strb 4'hF, then load addr 3 -> store response rdata DEADBEEF err 0; load returns 32'hCAFEF00D RD_LATENCY cycles after accept.
REQ-034 Addr 5 holds 32'h11223344; store 32'hAABBCCDD strb 4'b0101; load addr 5 -> 32'h11BB33DD with MEM_BYTE_STROBE_EN, 32'hAABBCCDD without it.
REQ-035 RD_LATENCY=2, rsp_ready=0, back-to-back loads -> exactly 3 accepted, then req_ready=0; raise rsp_ready -> 3 responses in order, no loss, and req_ready reasserts the cycle after the first pop.
REQ-036 NUM_WORDS=100: store to addr 120, then load addr 120 -> both responses err=1 with rdata DEADBEEF, and words 0..99 unchanged.
REQ-037 Continuous loads with rsp_ready=1 -> one response per cycle, sustained, with accept and pop in the same cycle keeping outstanding constant.
REQ-038 Assert rst asynchronously with 2 responses queued -> rsp_valid drops immediately, no stale response after release, and earlier store data is still readable.

Source files
------------

// File: rtl/mem_ctrl_pipe_if.sv
// Request/response bus of the pipelined word memory controller.
// The master issues requests and consumes responses; the slave is the controller.
interface mem_ctrl_pipe_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 7
);
    logic                      req_valid;
    logic                      req_ready;
    logic                      req_we;
    logic [ADDR_WIDTH-1:0]     req_addr;
    logic [DATA_WIDTH-1:0]     req_wdata;
    logic [DATA_WIDTH/8-1:0]   req_wstrb;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [DATA_WIDTH-1:0]     rsp_rdata;
    logic                      rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/mem_ctrl_pipe.sv
// Word memory with valid/ready requests, RD_LATENCY-cycle read pipeline and an
// in-order response FIFO. Macro MEM_BYTE_STROBE_EN enables byte write strobes.
module mem_ctrl_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 7,
    parameter int NUM_WORDS  = 128,
    parameter int RD_LATENCY = 1,
    parameter int INIT_BY    = 0
) (
    input  logic              clk,
    input  logic              rst,
    mem_ctrl_pipe_if.slave    bus
);
    localparam int DEPTH  = RD_LATENCY + 1;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int IDX_W  = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int STRB_W = DATA_WIDTH / 8;

    localparam logic [PTR_W-1:0]      PTR_LAST    = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]      CNT_DEPTH   = CNT_W'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   WORDS_LIMIT = (ADDR_WIDTH+1)'(NUM_WORDS);
    localparam logic [31:0]           PAT32       = 32'hDEADBEEF;

    // No preload image is loaded by this RTL; INIT_BY is kept for interface compatibility.
    localparam int init_by_unused = INIT_BY;

    function automatic logic [DATA_WIDTH-1:0] f_pattern();
        logic [DATA_WIDTH-1:0] v;
        v = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            v[i] = PAT32[i % 32];
        end
        return v;
    endfunction

    localparam logic [DATA_WIDTH-1:0] DEADBEEF = f_pattern();

    function automatic logic [PTR_W-1:0] f_next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
    endfunction

    logic [DATA_WIDTH-1:0] r_mem [NUM_WORDS];

    logic                  r_req_ready;
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic [CNT_W-1:0]      r_outstanding;
    logic [DATA_WIDTH-1:0] r_fifo_data [DEPTH];
    logic                  r_fifo_err  [DEPTH];

    logic                  w_accept;
    logic                  w_pop;
    logic                  w_fifo_nempty;
    logic                  w_in_range;
    logic [IDX_W-1:0]      w_word_idx;
    logic [DATA_WIDTH-1:0] w_rsp_data;
    logic                  w_rsp_err;
    logic [DATA_WIDTH-1:0] w_wr_word;
    logic                  w_push;
    logic [DATA_WIDTH-1:0] w_push_data;
    logic                  w_push_err;
    logic [CNT_W-1:0]      w_outstanding_nxt;
    logic [CNT_W-1:0]      w_count_nxt;

    assign w_fifo_nempty = (r_count != '0);
    assign w_accept      = bus.req_valid && r_req_ready;
    assign w_pop         = w_fifo_nempty && bus.rsp_ready;
    assign w_in_range    = ({1'b0, bus.req_addr} < WORDS_LIMIT);
    assign w_word_idx    = bus.req_addr[IDX_W-1:0];

    // Response content is fixed at accept time; later stores cannot alter it.
    always_comb begin
        w_rsp_data = DEADBEEF;
        w_rsp_err  = !w_in_range;
        if (!bus.req_we && w_in_range) begin
            w_rsp_data = r_mem[w_word_idx];
        end
    end

`ifdef MEM_BYTE_STROBE_EN
    always_comb begin
        w_wr_word = r_mem[w_word_idx];
        for (int b = 0; b < STRB_W; b++) begin
            if (bus.req_wstrb[b]) begin
                w_wr_word[8*b +: 8] = bus.req_wdata[8*b +: 8];
            end
        end
    end
`else
    logic w_wstrb_unused;
    assign w_wstrb_unused = ^bus.req_wstrb;
    assign w_wr_word      = bus.req_wdata;
`endif

    // NOTE: storage arrays carry no reset so they map onto RAM and survive rst.
    always_ff @(posedge clk) begin
        if (w_accept && bus.req_we && w_in_range) begin
            r_mem[w_word_idx] <= w_wr_word;
        end
    end

    generate
        if (RD_LATENCY == 2) begin : g_lat2
            logic                  r_p_valid;
            logic [DATA_WIDTH-1:0] r_p_data;
            logic                  r_p_err;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_p_valid <= 1'b0;
                    r_p_data  <= DEADBEEF;
                    r_p_err   <= 1'b0;
                end else begin
                    r_p_valid <= w_accept;
                    if (w_accept) begin
                        r_p_data <= w_rsp_data;
                        r_p_err  <= w_rsp_err;
                    end
                end
            end

            assign w_push      = r_p_valid;
            assign w_push_data = r_p_data;
            assign w_push_err  = r_p_err;
        end else begin : g_lat1
            assign w_push      = w_accept;
            assign w_push_data = w_rsp_data;
            assign w_push_err  = w_rsp_err;
        end
    endgenerate

    // Outstanding bounds pipeline + FIFO occupancy, so a push never meets a full FIFO.
    always_comb begin
        w_outstanding_nxt = r_outstanding;
        w_count_nxt       = r_count;
        case ({w_accept, w_pop})
            2'b10:   w_outstanding_nxt = r_outstanding + 1'b1;
            2'b01:   w_outstanding_nxt = r_outstanding - 1'b1;
            default: w_outstanding_nxt = r_outstanding;
        endcase
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_data[r_wr_ptr] <= w_push_data;
            r_fifo_err[r_wr_ptr]  <= w_push_err;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_outstanding <= '0;
            r_req_ready   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= f_next_ptr(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= f_next_ptr(r_rd_ptr);
            end
            r_count       <= w_count_nxt;
            r_outstanding <= w_outstanding_nxt;
            r_req_ready   <= (w_outstanding_nxt < CNT_DEPTH);
        end
    end

    assign bus.req_ready = r_req_ready;
    assign bus.rsp_valid = w_fifo_nempty;
    assign bus.rsp_rdata = w_fifo_nempty ? r_fifo_data[r_rd_ptr] : DEADBEEF;
    assign bus.rsp_err   = w_fifo_nempty && r_fifo_err[r_rd_ptr];

endmodule

// File: tb/tb_mem_ctrl_pipe.sv
// Self-checking bench for mem_ctrl_pipe (RD_LATENCY=2, NUM_WORDS=100): random and
// directed traffic scored against a queue-based model of the expected responses.
module tb_mem_ctrl_pipe;
    localparam int DW    = 32;
    localparam int AW    = 7;
    localparam int NW    = 100;
    localparam int LAT   = 2;
    localparam int DEPTH = LAT + 1;
    localparam logic [31:0] PATTERN = 32'hDEADBEEF;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    mem_ctrl_pipe_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    mem_ctrl_pipe #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .NUM_WORDS  (NW),
        .RD_LATENCY (LAT),
        .INIT_BY    (0)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t        exp_q[$];
    logic [31:0] model_mem [NW];
    int          cyc;
    int          n_checks;
    int          n_errors;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] st);
        logic [3:0]  m;
        logic [31:0] r;
`ifdef MEM_BYTE_STROBE_EN
        m = st;
`else
        m = 4'hF;
`endif
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (m[i]) r[8*i +: 8] = wd[8*i +: 8];
        end
        return r;
    endfunction

    // One clock: drive at the falling edge, compare 1 ns later, score the coming rising edge.
    task automatic cycle_step(input logic v, input logic we, input logic [AW-1:0] addr,
                              input logic [31:0] wd, input logic [3:0] st, input logic rdy,
                              output logic acc);
        logic exp_valid;
        exp_t e;
        @(negedge clk);
        bus.req_valid = v;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        bus.req_wstrb = st;
        bus.rsp_ready = rdy;
        #1;
        cyc++;
        check("req_ready", 32'(bus.req_ready), 32'(exp_q.size() < DEPTH));
        exp_valid = (exp_q.size() > 0) && (cyc - exp_q[0].acc >= LAT);
        check("rsp_valid", 32'(bus.rsp_valid), 32'(exp_valid));
        if (exp_valid && bus.rsp_valid) begin
            check("rsp_rdata", bus.rsp_rdata, exp_q[0].data);
            check("rsp_err", 32'(bus.rsp_err), 32'(exp_q[0].err));
        end
        if (bus.rsp_valid && rdy && exp_q.size() > 0) begin
            e = exp_q.pop_front();
        end
        acc = v && bus.req_ready;
        if (acc) begin
            e.acc = cyc;
            e.err = (int'(addr) >= NW);
            e.data = (e.err || we) ? PATTERN : model_mem[int'(addr)];
            if (we && !e.err) model_mem[int'(addr)] = merge(model_mem[int'(addr)], wd, st);
            exp_q.push_back(e);
        end
    endtask

    task automatic issue(input logic we, input logic [AW-1:0] addr, input logic [31:0] wd,
                         input logic [3:0] st);
        logic acc;
        int   tries;
        acc   = 1'b0;
        tries = 0;
        while (!acc && tries < 20) begin
            cycle_step(1'b1, we, addr, wd, st, 1'b1, acc);
            tries++;
        end
        if (!acc) check("issue_accept", 32'(acc), 32'd1);
    endtask

    task automatic idle(input int n, input logic rdy);
        logic acc;
        for (int i = 0; i < n; i++) cycle_step(1'b0, 1'b0, '0, '0, '0, rdy, acc);
    endtask

    task automatic drain();
        int tries;
        tries = 0;
        while (exp_q.size() > 0 && tries < 50) begin
            idle(1, 1'b1);
            tries++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        logic acc;
        int   n_acc;
        n_checks = 0;
        n_errors = 0;
        cyc      = 0;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_wstrb = '0;
        bus.rsp_ready = 1'b0;

        // Values held while reset is asserted.
        repeat (3) @(negedge clk);
        #1;
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        check("rst_rsp_rdata", bus.rsp_rdata, PATTERN);
        @(negedge clk);
        rst = 1'b0;
        idle(2, 1'b1);

        // Give every implemented word a known value.
        for (int a = 0; a < NW; a++) issue(1'b1, AW'(a), $urandom, 4'hF);
        drain();

        // Store then load, latency checked by the rsp_valid model.
        issue(1'b1, 7'd3, 32'hCAFEF00D, 4'hF);
        issue(1'b0, 7'd3, '0, '0);
        drain();

        // Partial-strobe store.
        issue(1'b1, 7'd5, 32'h11223344, 4'hF);
        issue(1'b1, 7'd5, 32'hAABBCCDD, 4'b0101);
        issue(1'b0, 7'd5, '0, '0);
        drain();

        // Back-pressure: only DEPTH loads may be accepted.
        n_acc = 0;
        for (int i = 0; i < 6; i++) begin
            cycle_step(1'b1, 1'b0, AW'($urandom_range(0, NW - 1)), '0, '0, 1'b0, acc);
            n_acc += int'(acc);
        end
        check("backpressure_accepts", 32'(n_acc), 32'(DEPTH));
        idle(2, 1'b0);
        drain();

        // Out-of-range store and load, then every in-range word still intact.
        issue(1'b1, 7'd120, 32'h0BADF00D, 4'hF);
        issue(1'b0, 7'd120, '0, '0);
        drain();
        for (int a = 0; a < NW; a++) issue(1'b0, AW'(a), '0, '0);
        drain();

        // Sustained streaming with rsp_ready held high.
        n_acc = 0;
        for (int i = 0; i < 40; i++) begin
            cycle_step(1'b1, 1'b0, AW'($urandom_range(0, NW - 1)), '0, '0, 1'b1, acc);
            n_acc += int'(acc);
        end
        check("stream_accepts", 32'(n_acc), 32'd40);
        drain();

        // Random mixed traffic with random back-pressure.
        for (int i = 0; i < 300; i++) begin
            cycle_step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       AW'($urandom_range(0, 127)), $urandom, 4'($urandom_range(0, 15)),
                       ($urandom_range(0, 3) != 0), acc);
        end
        drain();

        // Asynchronous reset with two responses queued.
        cycle_step(1'b1, 1'b0, 7'd7, '0, '0, 1'b0, acc);
        cycle_step(1'b1, 1'b0, 7'd9, '0, '0, 1'b0, acc);
        idle(3, 1'b0);
        check("queued_before_rst", 32'(bus.rsp_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("async_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("async_rst_req_ready", 32'(bus.req_ready), 32'd0);
        check("async_rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        check("async_rst_rsp_rdata", bus.rsp_rdata, PATTERN);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle(4, 1'b1);
        issue(1'b0, 7'd3, '0, '0);
        issue(1'b0, 7'd5, '0, '0);
        for (int i = 0; i < 10; i++) issue(1'b0, AW'($urandom_range(0, NW - 1)), '0, '0);
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
